// File: rtl/cnnip_pool_ctrlr_if.sv
`default_nettype none
// cnnip_pool_ctrlr_if: command/status and memory-port bundle of the pooling post-processor.
// Rev 1.0
interface cnnip_pool_ctrlr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  CMD_START;
  logic [7:0]            MODE_FMAP_SIZE;
  logic                  MODE_POOL_EN;
  logic                  MODE_RELU_EN;
  logic                  CMD_DONE;
  logic                  CMD_DONE_VALID;
  logic                  BUSY;
  logic                  src_en;
  logic                  src_we;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [DATA_WIDTH-1:0] src_dout;
  logic                  dst_en;
  logic                  dst_we;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [DATA_WIDTH-1:0] dst_din;

  modport slave (
    input  CMD_START, MODE_FMAP_SIZE, MODE_POOL_EN, MODE_RELU_EN, src_dout,
    output CMD_DONE, CMD_DONE_VALID, BUSY, src_en, src_we, src_addr,
           dst_en, dst_we, dst_addr, dst_din
  );

  modport master (
    output CMD_START, MODE_FMAP_SIZE, MODE_POOL_EN, MODE_RELU_EN, src_dout,
    input  CMD_DONE, CMD_DONE_VALID, BUSY, src_en, src_we, src_addr,
           dst_en, dst_we, dst_addr, dst_din
  );
endinterface
`default_nettype wire

// File: rtl/cnnip_pool_ctrlr.sv
`default_nettype none
// cnnip_pool_ctrlr: reads the NxN conv map, applies optional ReLU and 2x2/s2 max pooling, writes result.
// Rev 1.0
module cnnip_pool_ctrlr #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    READ_LATENCY = 2,
  parameter logic [ADDR_WIDTH-1:0] SRC_BASE     = 12'h300,
  parameter logic [ADDR_WIDTH-1:0] DST_BASE     = 12'h400
) (
  input  wire logic         clk_a,
  input  wire logic         arstz_aq,
  cnnip_pool_ctrlr_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                  state_q;
  logic [7:0]              n_q, o_q, ox_q, oy_q;
  logic                    pool_q, relu_q;
  logic [2:0]              rd_cnt_q;
  logic                    src_en_q, dst_en_q, done_q, busy_q;
  logic [ADDR_WIDTH-1:0]   src_addr_q, dst_addr_q;
  logic [DATA_WIDTH-1:0]   dst_din_q;
  logic [DATA_WIDTH-1:0]   max_q, max_d;
  logic [READ_LATENCY-1:0] vld_pipe_q, first_pipe_q, last_pipe_q;

  logic [7:0] w_o_start;
  logic [2:0] w_rd_total;
  logic       w_last_out;
  logic [7:0] w_nx_ox, w_nx_oy;
  logic       w_last_cap;

  function automatic logic [ADDR_WIDTH-1:0] f_src_addr(
    input logic [7:0] n, input logic pool, input logic [7:0] ox,
    input logic [7:0] oy, input logic [1:0] idx);
    logic [ADDR_WIDTH-1:0] row, col;
    if (pool) begin
      row = ADDR_WIDTH'({oy, 1'b0}) + ADDR_WIDTH'(idx[1]);
      col = ADDR_WIDTH'({ox, 1'b0}) + ADDR_WIDTH'(idx[0]);
    end else begin
      row = ADDR_WIDTH'(oy);
      col = ADDR_WIDTH'(ox);
    end
    return SRC_BASE + ((row * ADDR_WIDTH'(n) + col) << 2);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_dst_addr(
    input logic [7:0] o, input logic [7:0] ox, input logic [7:0] oy);
    return DST_BASE + ((ADDR_WIDTH'(oy) * ADDR_WIDTH'(o) + ADDR_WIDTH'(ox)) << 2);
  endfunction

  assign w_o_start  = bus.MODE_POOL_EN ? {1'b0, bus.MODE_FMAP_SIZE[7:1]} : bus.MODE_FMAP_SIZE;
  assign w_rd_total = pool_q ? 3'd4 : 3'd1;
  assign w_last_out = (ox_q == o_q - 8'd1) && (oy_q == o_q - 8'd1);
  assign w_nx_ox    = (ox_q == o_q - 8'd1) ? 8'd0 : ox_q + 8'd1;
  assign w_nx_oy    = (ox_q == o_q - 8'd1) ? ((oy_q == o_q - 8'd1) ? 8'd0 : oy_q + 8'd1) : oy_q;
  assign w_last_cap = vld_pipe_q[READ_LATENCY-1] && last_pipe_q[READ_LATENCY-1];

  // Running signed max; the first word of each window reloads it.
  always_comb begin
    max_d = max_q;
    if (vld_pipe_q[READ_LATENCY-1]) begin
      if (first_pipe_q[READ_LATENCY-1] || ($signed(bus.src_dout) > $signed(max_q))) begin
        max_d = bus.src_dout;
      end
    end
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
      max_q        <= '0;
    end else begin
      vld_pipe_q[0]   <= src_en_q;
      first_pipe_q[0] <= src_en_q && (rd_cnt_q == 3'd1);
      last_pipe_q[0]  <= src_en_q && (rd_cnt_q == w_rd_total);
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_q[i]   <= vld_pipe_q[i-1];
        first_pipe_q[i] <= first_pipe_q[i-1];
        last_pipe_q[i]  <= last_pipe_q[i-1];
      end
      max_q <= max_d;
    end
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      o_q        <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      pool_q     <= 1'b0;
      relu_q     <= 1'b0;
      rd_cnt_q   <= '0;
      src_en_q   <= 1'b0;
      dst_en_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      src_addr_q <= SRC_BASE;
      dst_addr_q <= DST_BASE;
      dst_din_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.CMD_START) begin
            n_q    <= bus.MODE_FMAP_SIZE;
            pool_q <= bus.MODE_POOL_EN;
            relu_q <= bus.MODE_RELU_EN;
            o_q    <= w_o_start;
            ox_q   <= '0;
            oy_q   <= '0;
            busy_q <= 1'b1;
            if (w_o_start == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_READ;
              src_en_q   <= 1'b1;
              src_addr_q <= f_src_addr(bus.MODE_FMAP_SIZE, bus.MODE_POOL_EN, 8'd0, 8'd0, 2'd0);
              rd_cnt_q   <= 3'd1;
            end
          end
        end
        // rd_cnt_q counts reads issued including the one on the bus this cycle.
        S_READ: begin
          if (rd_cnt_q == w_rd_total) begin
            state_q  <= S_WAIT;
            src_en_q <= 1'b0;
          end else begin
            src_addr_q <= f_src_addr(n_q, pool_q, ox_q, oy_q, rd_cnt_q[1:0]);
            rd_cnt_q   <= rd_cnt_q + 3'd1;
          end
        end
        S_WAIT: begin
          if (w_last_cap) begin
            state_q    <= S_WRITE;
            dst_en_q   <= 1'b1;
            dst_addr_q <= f_dst_addr(o_q, ox_q, oy_q);
            dst_din_q  <= (relu_q && max_d[DATA_WIDTH-1]) ? '0 : max_d;
          end
        end
        S_WRITE: begin
          dst_en_q <= 1'b0;
          ox_q     <= w_nx_ox;
          oy_q     <= w_nx_oy;
          if (w_last_out) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= S_READ;
            src_en_q   <= 1'b1;
            src_addr_q <= f_src_addr(n_q, pool_q, w_nx_ox, w_nx_oy, 2'd0);
            rd_cnt_q   <= 3'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.CMD_DONE       = done_q;
  assign bus.CMD_DONE_VALID = done_q;
  assign bus.BUSY           = busy_q;
  assign bus.src_en         = src_en_q;
  assign bus.src_we         = 1'b0;
  assign bus.src_addr       = src_addr_q;
  assign bus.dst_en         = dst_en_q;
  assign bus.dst_we         = dst_en_q;
  assign bus.dst_addr       = dst_addr_q;
  assign bus.dst_din        = dst_din_q;

endmodule
`default_nettype wire

// File: tb/tb_cnnip_pool_ctrlr.sv
`default_nettype none
// tb_cnnip_pool_ctrlr: vector table plus read/write scoreboards for cnnip_pool_ctrlr.
// Rev 1.0
module tb_cnnip_pool_ctrlr;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int LAT = 2;
  localparam logic [AW-1:0] SRC_BASE = 12'h300;
  localparam logic [AW-1:0] DST_BASE = 12'h400;

  logic clk_a    = 1'b0;
  logic arstz_aq = 1'b1;
  always #5 clk_a = ~clk_a;

  cnnip_pool_ctrlr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cnnip_pool_ctrlr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT),
    .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE)
  ) dut (
    .clk_a(clk_a), .arstz_aq(arstz_aq), .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } ev_t;

  typedef struct {
    int              n;
    bit              pool;
    bit              relu;
    int              map;
    int              nexp;
    logic [8:0][31:0] exp;
    int              exp_wr;
    int              exp_rd;
    int              exp_done;
  } vec_t;

  vec_t vecs[9];
  ev_t  rd_q[$];
  ev_t  wr_q[$];
  ev_t  mon_e;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_pipe [LAT];

  int checks = 0, passes = 0;
  int cyc = 0, start_cyc = 0;
  int reads_seen = 0, writes_seen = 0, done_seen = 0, done_cyc = 0;

  int e1[4] = '{6, 8, 0, 9};
  int e2[4] = '{-1, -3, -11, -13};
  int e3[9] = '{0, 0, 0, 0, 0, 1, 2, 3, 4};
  int m1[16] = '{1, -2, 3, 4, 5, 6, -7, 8, -1, -2, -3, -4, -5, -6, 9, 0};

  // Feature memory with a fixed read pipeline of LAT cycles.
  always @(posedge clk_a) begin
    rd_pipe[0] <= bus.src_en ? mem[8'((bus.src_addr - SRC_BASE) >> 2)] : '0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.src_dout = rd_pipe[LAT-1];

  always @(posedge clk_a) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  always @(negedge clk_a) begin
    if (arstz_aq) begin
      if (bus.src_en) begin
        reads_seen++;
        if (rd_q.size() == 0) chk(1'b0, "unexpected_read", longint'(bus.src_addr), -1);
        else begin
          mon_e = rd_q.pop_front();
          chk(bus.src_addr == mon_e.addr, "read_addr", longint'(bus.src_addr), longint'(mon_e.addr));
          chk(cyc == mon_e.cyc, "read_cycle", cyc, mon_e.cyc);
          chk(bus.src_we == 1'b0, "src_we", longint'(bus.src_we), 0);
        end
      end
      if (bus.dst_en) begin
        writes_seen++;
        if (wr_q.size() == 0) chk(1'b0, "unexpected_write", longint'(bus.dst_addr), -1);
        else begin
          mon_e = wr_q.pop_front();
          chk(bus.dst_addr == mon_e.addr, "write_addr", longint'(bus.dst_addr), longint'(mon_e.addr));
          chk(bus.dst_din == mon_e.data, "write_data", longint'($signed(bus.dst_din)),
              longint'($signed(mon_e.data)));
          chk(cyc == mon_e.cyc, "write_cycle", cyc, mon_e.cyc);
          chk(bus.dst_we == 1'b1, "dst_we", longint'(bus.dst_we), 1);
        end
      end
      if (bus.CMD_DONE || bus.CMD_DONE_VALID) begin
        done_seen++;
        done_cyc = cyc;
        chk(bus.CMD_DONE == bus.CMD_DONE_VALID, "done_valid", longint'(bus.CMD_DONE_VALID),
            longint'(bus.CMD_DONE));
      end
    end
  end

  task automatic set_vec(input int i, input int n, input bit pool, input bit relu, input int map,
                         input int wr, input int rd, input int dn);
    vecs[i].n = n; vecs[i].pool = pool; vecs[i].relu = relu; vecs[i].map = map;
    vecs[i].nexp = 0; vecs[i].exp = '0;
    vecs[i].exp_wr = wr; vecs[i].exp_rd = rd; vecs[i].exp_done = dn;
  endtask

  // Fills the map and pushes the expected read/write sequence for vector v.
  task automatic build(input int v);
    int n, o, w, p, k, row, col, val, mx;
    ev_t t;
    n = vecs[v].n;
    o = vecs[v].pool ? n / 2 : n;
    w = vecs[v].pool ? 4 : 1;
    p = w + LAT + 1;
    for (int i = 0; i < 256; i++) begin
      if (i >= n * n)            mem[i] = 32'hDEAD_BEEF;
      else if (vecs[v].map == 0) mem[i] = 32'(m1[i]);
      else if (vecs[v].map == 1) mem[i] = 32'(-(i + 1));
      else if (vecs[v].map == 2) mem[i] = 32'(i - 4);
      else                       mem[i] = $urandom;
    end
    rd_q.delete();
    wr_q.delete();
    for (int oy = 0; oy < o; oy++) begin
      for (int ox = 0; ox < o; ox++) begin
        k  = oy * o + ox;
        mx = 0;
        for (int j = 0; j < w; j++) begin
          row = vecs[v].pool ? 2 * oy + j / 2 : oy;
          col = vecs[v].pool ? 2 * ox + j % 2 : ox;
          t.addr = AW'(int'(SRC_BASE) + 4 * (row * n + col));
          t.data = '0;
          t.cyc  = start_cyc + 1 + k * p + j;
          rd_q.push_back(t);
          val = $signed(mem[row * n + col]);
          if (j == 0 || val > mx) mx = val;
        end
        if (vecs[v].relu && mx < 0) mx = 0;
        t.addr = AW'(int'(DST_BASE) + 4 * k);
        t.data = (vecs[v].nexp > 0) ? vecs[v].exp[k] : 32'(mx);
        t.cyc  = start_cyc + (k + 1) * p;
        wr_q.push_back(t);
      end
    end
  endtask

  task automatic start_pass(input int v);
    @(negedge clk_a);
    start_cyc   = cyc;
    reads_seen  = 0;
    writes_seen = 0;
    done_seen   = 0;
    build(v);
    bus.CMD_START      = 1'b1;
    bus.MODE_FMAP_SIZE = 8'(vecs[v].n);
    bus.MODE_POOL_EN   = vecs[v].pool;
    bus.MODE_RELU_EN   = vecs[v].relu;
    @(negedge clk_a);
    bus.CMD_START      = 1'b0;
    bus.MODE_FMAP_SIZE = 8'd9;
    bus.MODE_POOL_EN   = ~vecs[v].pool;
    bus.MODE_RELU_EN   = ~vecs[v].relu;
    chk(bus.BUSY == 1'b1, "busy_after_start", longint'(bus.BUSY), 1);
  endtask

  task automatic finish_pass(input int v);
    int budget;
    budget = vecs[v].exp_done + 20;
    while (done_seen == 0 && budget > 0) begin
      @(negedge clk_a);
      budget--;
    end
    repeat (3) @(negedge clk_a);
    chk(done_seen == 1, "done_count", done_seen, 1);
    chk(done_cyc - start_cyc == vecs[v].exp_done, "done_cycle", done_cyc - start_cyc, vecs[v].exp_done);
    chk(writes_seen == vecs[v].exp_wr, "write_count", writes_seen, vecs[v].exp_wr);
    chk(reads_seen == vecs[v].exp_rd, "read_count", reads_seen, vecs[v].exp_rd);
    chk(rd_q.size() == 0, "reads_left", rd_q.size(), 0);
    chk(wr_q.size() == 0, "writes_left", wr_q.size(), 0);
    chk(bus.BUSY == 1'b0, "busy_idle", longint'(bus.BUSY), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(bus.src_en == 1'b0 && bus.dst_en == 1'b0 && bus.dst_we == 1'b0 && bus.src_we == 1'b0,
        {tag, "_enables"}, longint'({bus.src_en, bus.src_we, bus.dst_en, bus.dst_we}), 0);
    chk(bus.CMD_DONE == 1'b0 && bus.CMD_DONE_VALID == 1'b0 && bus.BUSY == 1'b0,
        {tag, "_status"}, longint'({bus.CMD_DONE, bus.CMD_DONE_VALID, bus.BUSY}), 0);
    chk(bus.src_addr == SRC_BASE, {tag, "_src_addr"}, longint'(bus.src_addr), longint'(SRC_BASE));
    chk(bus.dst_addr == DST_BASE, {tag, "_dst_addr"}, longint'(bus.dst_addr), longint'(DST_BASE));
    chk(bus.dst_din == '0, {tag, "_dst_din"}, longint'(bus.dst_din), 0);
  endtask

  initial begin
    int budget;
    // n pool relu map writes reads done_offset(=O*O*(W+LAT+1)+1)
    set_vec(0,  4, 1, 1, 0,   4,  16,   29);
    set_vec(1,  5, 1, 0, 1,   4,  16,   29);
    set_vec(2,  3, 0, 1, 2,   9,   9,   37);
    set_vec(3,  1, 1, 1, 1,   0,   0,    1);
    set_vec(4,  0, 0, 0, 3,   0,   0,    1);
    set_vec(5, 15, 0, 0, 3, 225, 225,  901);
    set_vec(6, 15, 1, 1, 3,  49, 196,  344);
    set_vec(7,  2, 1, 0, 3,   1,   4,    8);
    set_vec(8,  7, 1, 0, 1,   9,  36,   64);
    vecs[0].nexp = 4; for (int i = 0; i < 4; i++) vecs[0].exp[i] = 32'(e1[i]);
    vecs[1].nexp = 4; for (int i = 0; i < 4; i++) vecs[1].exp[i] = 32'(e2[i]);
    vecs[2].nexp = 9; for (int i = 0; i < 9; i++) vecs[2].exp[i] = 32'(e3[i]);

    bus.CMD_START = 1'b0;
    bus.MODE_FMAP_SIZE = 8'd0;
    bus.MODE_POOL_EN = 1'b0;
    bus.MODE_RELU_EN = 1'b0;
    #1 arstz_aq = 1'b0;
    repeat (3) @(negedge clk_a);
    chk_reset_outputs("reset");
    arstz_aq = 1'b1;
    repeat (2) @(negedge clk_a);

    for (int v = 0; v < 9; v++) begin
      start_pass(v);
      finish_pass(v);
    end

    // START while busy (READ) and again during the DONE cycle: both ignored.
    start_pass(0);
    @(negedge clk_a);
    bus.CMD_START = 1'b1;
    bus.MODE_FMAP_SIZE = 8'd3;
    bus.MODE_POOL_EN = 1'b0;
    @(negedge clk_a);
    bus.CMD_START = 1'b0;
    budget = 40;
    while (!bus.CMD_DONE && budget > 0) begin
      @(negedge clk_a);
      budget--;
    end
    bus.CMD_START = 1'b1;
    @(negedge clk_a);
    bus.CMD_START = 1'b0;
    repeat (6) @(negedge clk_a);
    finish_pass(0);

    // Asynchronous reset in the second window aborts the pass silently.
    start_pass(0);
    budget = 20;
    while (writes_seen == 0 && budget > 0) begin
      @(negedge clk_a);
      budget--;
    end
    @(negedge clk_a);
    #2 arstz_aq = 1'b0;
    #1 chk_reset_outputs("abort");
    rd_q.delete();
    wr_q.delete();
    repeat (3) @(negedge clk_a);
    arstz_aq = 1'b1;
    repeat (4) @(negedge clk_a);
    chk(done_seen == 0, "no_done_after_abort", done_seen, 0);
    chk(bus.BUSY == 1'b0, "idle_after_abort", longint'(bus.BUSY), 0);
    start_pass(0);
    finish_pass(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
